// File: rtl/organ_serial_driver_if.sv
// Lamp-frame handshake between the light-organ lamp state and the serial driver.
// A frame transfers on any clock where lamps_valid and lamps_ready are both high.
interface organ_serial_driver_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] lamps;
    logic             lamps_valid;
    logic             lamps_ready;

    modport master (output lamps, output lamps_valid, input  lamps_ready);
    modport slave  (input  lamps, input  lamps_valid, output lamps_ready);
endinterface

// File: rtl/organ_serial_driver.sv
// Shifts a lamp frame MSB-first to the DS8205D board as data/clock/latch on the open-drain user port.
// Registered outputs; ready only in IDLE, so frames offered while busy wait; stored frame re-sent on idle timeout.
module organ_serial_driver #(
    parameter int NBITS   = 8,
    parameter int CLK_DIV = 16,
    parameter int REFRESH = 1000000
) (
    input  logic                 clk_sys_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    organ_serial_driver_if.slave lamp_if,
    output logic                 busy_o,
    output logic [6:0]           user_out_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
    localparam logic [RW-1:0] REF_LAST = (REFRESH == 0) ? '0 : RW'(REFRESH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [RW-1:0]    refresh_q, refresh_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [NBITS-1:0] stored_q, stored_d;
    logic [6:0]       user_out_q, user_out_d;
    logic             busy_q, busy_d;

    logic div_done;
    logic accept;
    logic refresh_hit;
    logic data_d, sclk_d, latch_d;

    assign lamp_if.lamps_ready = (state_q == ST_IDLE) && enable_i && !reset_i;
    assign busy_o     = busy_q;
    assign user_out_o = user_out_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        refresh_d   = refresh_q;
        shreg_d     = shreg_q;
        stored_d    = stored_q;
        accept      = 1'b0;
        refresh_hit = 1'b0;
        div_done    = (div_q == DIV_LAST);

        if (!enable_i) begin
            // Abandon any partial frame; the stored frame survives for the next refresh.
            state_d   = ST_IDLE;
            div_d     = '0;
            bit_d     = '0;
            refresh_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    accept      = lamp_if.lamps_valid;
                    refresh_hit = (REFRESH != 0) && (refresh_q == REF_LAST) && !accept;
                    if (accept) begin
                        stored_d  = lamp_if.lamps;
                        shreg_d   = lamp_if.lamps;
                        state_d   = ST_SHIFT_LO;
                        div_d     = '0;
                        bit_d     = '0;
                        refresh_d = '0;
                    end else if (refresh_hit) begin
                        shreg_d   = stored_q;
                        state_d   = ST_SHIFT_LO;
                        div_d     = '0;
                        bit_d     = '0;
                        refresh_d = '0;
                    end else if (REFRESH != 0) begin
                        refresh_d = refresh_q + 1'b1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_done) begin
                        div_d   = '0;
                        state_d = ST_SHIFT_HI;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_done) begin
                        div_d = '0;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = ST_LATCH;
                        end else begin
                            shreg_d = shreg_q << 1;
                            bit_d   = bit_q + 1'b1;
                            state_d = ST_SHIFT_LO;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (div_done) begin
                        div_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (div_done) begin
                        div_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    bit_d   = '0;
                end
            endcase
        end

        // Serial lines are decoded from the next state so the pins line up with state_q.
        data_d  = 1'b0;
        sclk_d  = 1'b0;
        latch_d = 1'b0;
        case (state_d)
            ST_SHIFT_LO: data_d = shreg_d[NBITS-1];
            ST_SHIFT_HI: begin
                data_d = shreg_d[NBITS-1];
                sclk_d = 1'b1;
            end
            ST_LATCH:    latch_d = 1'b1;
            default:     ;
        endcase

        user_out_d = enable_i ? {2'b11, latch_d, sclk_d, data_d, 2'b11} : 7'h7F;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            refresh_q  <= '0;
            shreg_q    <= '0;
            stored_q   <= '0;
            user_out_q <= 7'b1100011;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            refresh_q  <= refresh_d;
            shreg_q    <= shreg_d;
            stored_q   <= stored_d;
            user_out_q <= user_out_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_organ_serial_driver.sv
// Directed bench for organ_serial_driver with NBITS=8, CLK_DIV=2, REFRESH=50.
module tb_organ_serial_driver;

    logic       clk_sys;
    logic       reset;
    logic       enable;
    logic       busy;
    logic [6:0] user_out;

    organ_serial_driver_if #(.NBITS(8)) lif ();

    organ_serial_driver #(
        .NBITS  (8),
        .CLK_DIV(2),
        .REFRESH(50)
    ) dut (
        .clk_sys_i (clk_sys),
        .reset_i   (reset),
        .enable_i  (enable),
        .lamp_if   (lif),
        .busy_o    (busy),
        .user_out_o(user_out)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int         errors = 0;
    int         checks = 0;
    int         pin_bad = 0;
    logic [7:0] cap;
    int         ncap;
    int         nlatch;
    int         nbusy;
    logic       prev_sclk = 1'b0;
    int         n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cap    = 8'h00;
        ncap   = 0;
        nlatch = 0;
        nbusy  = 0;
    endtask

    // Advance to the next falling edge and record serial-bus activity seen there.
    task automatic step();
        @(negedge clk_sys);
        if (user_out[3] && !prev_sclk) begin
            cap  = {cap[6:0], user_out[2]};
            ncap++;
        end
        prev_sclk = user_out[3];
        if (user_out[4]) nlatch++;
        if (busy) nbusy++;
        if (user_out[1:0] !== 2'b11 || user_out[6:5] !== 2'b11) pin_bad++;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic wait_busy(input logic lvl, input int bound, output int cnt);
        cnt = 0;
        while (busy !== lvl && cnt < bound) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        reset           = 1'b1;
        enable          = 1'b1;
        lif.lamps       = 8'h00;
        lif.lamps_valid = 1'b0;
        clr();

        run(2);
        chk("rst_user_out", 32'(user_out), 32'h63);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(lif.lamps_ready), 32'd0);

        reset = 1'b0;
        #1;
        chk("idle_ready", 32'(lif.lamps_ready), 32'd1);

        // Basic frame 8'hA5
        lif.lamps       = 8'hA5;
        lif.lamps_valid = 1'b1;
        clr();
        step();
        chk("basic_ready_drop", 32'(lif.lamps_ready), 32'd0);
        chk("basic_busy_rise", 32'(busy), 32'd1);
        lif.lamps_valid = 1'b0;
        run(39);
        chk("basic_busy_cycles", 32'(nbusy), 32'd36);
        chk("basic_bits", 32'(cap), 32'hA5);
        chk("basic_nbits", 32'(ncap), 32'd8);
        chk("basic_latch_len", 32'(nlatch), 32'd2);
        chk("basic_lines_end", 32'(user_out[4:2]), 32'd0);
        chk("basic_ready_back", 32'(lif.lamps_ready), 32'd1);

        // Back-pressure: 8'h3C held while 8'hA5 is on the wire
        lif.lamps_valid = 1'b1;
        step();
        lif.lamps = 8'h3C;
        clr();
        n = 0;
        while (!lif.lamps_ready && n < 100) begin
            step();
            n++;
        end
        chk("bp_wait", 32'(n), 32'd36);
        chk("bp_first_frame", 32'(cap), 32'hA5);
        step();
        lif.lamps_valid = 1'b0;
        chk("bp_accept_busy", 32'(busy), 32'd1);
        clr();
        run(40);
        chk("bp_second_frame", 32'(cap), 32'h3C);
        chk("bp_second_nbits", 32'(ncap), 32'd8);

        // Auto-refresh of 8'h81
        lif.lamps       = 8'h81;
        lif.lamps_valid = 1'b1;
        step();
        lif.lamps_valid = 1'b0;
        wait_busy(1'b0, 100, n);
        chk("ref_frame_len", 32'(n), 32'd36);
        clr();
        wait_busy(1'b1, 100, n);
        chk("ref_gap1", 32'(n), 32'd50);
        wait_busy(1'b0, 100, n);
        chk("ref_resend_bits", 32'(cap), 32'h81);
        chk("ref_resend_nbits", 32'(ncap), 32'd8);
        wait_busy(1'b1, 100, n);
        chk("ref_gap2", 32'(n), 32'd50);
        wait_busy(1'b0, 100, n);

        // New frame offered exactly in the refresh cycle wins
        run(49);
        lif.lamps       = 8'h5A;
        lif.lamps_valid = 1'b1;
        step();
        lif.lamps_valid = 1'b0;
        chk("ref_collide_busy", 32'(busy), 32'd1);
        clr();
        wait_busy(1'b0, 100, n);
        chk("ref_collide_bits", 32'(cap), 32'h5A);
        clr();
        wait_busy(1'b1, 100, n);
        chk("ref_collide_gap", 32'(n), 32'd50);
        wait_busy(1'b0, 100, n);
        chk("ref_collide_stored", 32'(cap), 32'h5A);

        // Enable drop after the third bit of 8'hFF
        lif.lamps       = 8'hFF;
        lif.lamps_valid = 1'b1;
        step();
        lif.lamps_valid = 1'b0;
        run(11);
        enable = 1'b0;
        step();
        chk("en_drop_user_out", 32'(user_out), 32'h7F);
        chk("en_drop_busy", 32'(busy), 32'd0);
        chk("en_drop_ready", 32'(lif.lamps_ready), 32'd0);
        run(3);
        chk("en_low_user_out", 32'(user_out), 32'h7F);
        enable = 1'b1;
        #1;
        chk("en_rise_ready", 32'(lif.lamps_ready), 32'd1);
        clr();
        wait_busy(1'b1, 100, n);
        chk("en_refresh_gap", 32'(n), 32'd50);
        wait_busy(1'b0, 100, n);
        chk("en_refresh_bits", 32'(cap), 32'hFF);
        chk("en_refresh_nbits", 32'(ncap), 32'd8);
        chk("en_idle_user_out", 32'(user_out), 32'h63);

        // Reset during SHIFT_HI of 8'hC3
        lif.lamps       = 8'hC3;
        lif.lamps_valid = 1'b1;
        step();
        lif.lamps_valid = 1'b0;
        run(2);
        chk("rst_mid_sclk_high", 32'(user_out[3]), 32'd1);
        reset = 1'b1;
        step();
        chk("rst_mid_user_out", 32'(user_out), 32'h63);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        clr();
        wait_busy(1'b1, 100, n);
        chk("rst_refresh_gap", 32'(n), 32'd50);
        wait_busy(1'b0, 100, n);
        chk("rst_refresh_bits", 32'(cap), 32'h00);
        chk("rst_refresh_nbits", 32'(ncap), 32'd8);
        chk("rst_refresh_latch", 32'(nlatch), 32'd2);

        chk("pin_isolation", 32'(pin_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
